// File: rtl/rubik_cmd_seq.sv
// Move-command sequencer: buffers host move codes in a FIFO and issues one per
// cycle to the cube core, tracking run/solved state and a saturating move count.
module rubik_cmd_seq #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       s_valid_i,
  input  logic [3:0] s_cmd_i,
  output logic       s_ready_o,
  input  logic       pause_i,
  output logic [3:0] cmd_o,
  input  logic       done_i,
  output logic       solved_o,
  output logic [7:0] count_o,
  output logic       err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, SOLVED} state_t;

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          accept;
  logic          push;
  logic          pop;
  logic          illegal;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Ready depends on registered occupancy only, so a same-cycle pop never raises it.
  assign s_ready_o = (occ < FULL);
  assign accept    = s_valid_i & s_ready_o;
  assign push      = accept & (s_cmd_i != 4'd0) & (s_cmd_i <= 4'd12);
  assign illegal   = accept & (s_cmd_i >= 4'd13);
  assign pop       = (occ != '0) & ~pause_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s_cmd_i;
  end

  // Stage boundary: FIFO head -> registered cmd_o, with run/solved tracking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      cmd_o    <= 4'd0;
      count_o  <= 8'd0;
      err_o    <= 1'b0;
      solved_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
      cmd_o <= pop ? mem[rd_ptr] : 4'd0;
      if (illegal) err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= RUN;
            count_o <= 8'd1;
          end
        end
        RUN: begin
          if (pop) begin
            count_o <= sat_inc(count_o);
          end else if (done_i && (occ == '0) && (cmd_o == 4'd0)) begin
            state    <= SOLVED;
            solved_o <= 1'b1;
          end
        end
        SOLVED: begin
          if (pop) begin
            state    <= RUN;
            count_o  <= 8'd1;
            solved_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          solved_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
